// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control for a 5-stage pipeline.
// It also runs a memory-wait FSM with a timeout and keeps hazard performance counters.
module pipe_hazard_ctrl #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          CNT_W          = 32,
  parameter logic [1:0]  WB_MEM         = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             reg_wr_E,
  input  logic [1:0]       sel_wb_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_wr_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_wr_W,
  input  logic             branch_taken_E,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  logic tmo, mem_stall, lu, br_act, lu_act;
  always_comb begin
    tmo       = (state_q == WAIT) && (cnt_q == CNT_MAX);
    mem_stall = dmem_req_M && !dmem_ready && !tmo;
    lu        = reg_wr_E && sel_wb_E == WB_MEM && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D);
    br_act    = !mem_stall && branch_taken_E;
    lu_act    = !mem_stall && lu && !branch_taken_E;
    // The tmo cycle releases to IDLE, so M advances before any new wait can start.
    state_d        = mem_stall ? WAIT : IDLE;
    cnt_d          = (state_q == WAIT && mem_stall) ? cnt_q + 1'b1 : '0;
    mem_err_d      = tmo && dmem_req_M && !dmem_ready;
    stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, mem_stall || lu_act};
    flush_events_d = flush_events_q + {{(CNT_W-1){1'b0}}, br_act};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end
  assign stall_F      = mem_stall || lu_act;
  assign stall_D      = mem_stall || lu_act;
  assign stall_E      = mem_stall;
  assign stall_M      = mem_stall;
  assign flush_D      = br_act;
  assign flush_E      = br_act || lu_act;
  assign flush_W      = mem_stall;
  assign fwd_a_E      = (reg_wr_M && rd_M != 5'd0 && rd_M == rs1_E) ? 2'b10 :
                        (reg_wr_W && rd_W != 5'd0 && rd_W == rs1_E) ? 2'b01 : 2'b00;
  assign fwd_b_E      = (reg_wr_M && rd_M != 5'd0 && rd_M == rs2_E) ? 2'b10 :
                        (reg_wr_W && rd_W != 5'd0 && rd_W == rs2_E) ? 2'b01 : 2'b00;
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
endmodule
